// File: rtl/ball_step_ctrl_if.sv
// Ball step link between the step controller (master) and the ball block (slave).
//
// Handshake: o_ball_req is the master's request and stays high until the slave
// answers. The slave answers in one cycle with either i_ball_ack (step data on
// i_ballX/i_ballY/i_ball_size/i_ball_speedX/Y is valid in that same cycle) or
// i_ball_frame_term (no more steps this frame). The request stays high through
// the answering cycle. If both answers are high together, ack wins.
// o_ball_collision is a one-cycle pulse, and o_direc_var is valid during it.
interface ball_step_ctrl_if #(
  parameter int PX_W  = 10,
  parameter int PY_W  = 10,
  parameter int BS_W  = 4,
  parameter int DIR_W = 5
);
  logic             o_ball_req;
  logic             i_ball_ack;
  logic             i_ball_frame_term;
  logic [PX_W-1:0]  i_ballX;
  logic [PY_W-1:0]  i_ballY;
  logic [BS_W-1:0]  i_ball_size;
  logic [1:0]       i_ball_speedX;
  logic [1:0]       i_ball_speedY;
  logic             o_ball_collision;
  logic [DIR_W-1:0] o_direc_var;

  modport master (
    output o_ball_req, o_ball_collision, o_direc_var,
    input  i_ball_ack, i_ball_frame_term, i_ballX, i_ballY, i_ball_size,
           i_ball_speedX, i_ball_speedY
  );

  modport slave (
    input  o_ball_req, o_ball_collision, o_direc_var,
    output i_ball_ack, i_ball_frame_term, i_ballX, i_ballY, i_ball_size,
           i_ball_speedX, i_ball_speedY
  );
endinterface

// File: rtl/ball_step_ctrl.sv
// ball_step_ctrl: per frame, requests ball steps until the ball reports frame
// termination, checks every acknowledged step against walls, floor and
// platform, and reports collisions (with a direction code) and life loss.
module ball_step_ctrl #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int WALL_TOP    = 0,
  parameter int PLAT_W_LOG2 = 6,
  parameter int TIMEOUT     = 255,
  parameter int PX_W        = 10,
  parameter int PY_W        = 10,
  parameter int BS_W        = 4,
  parameter int DIR_W       = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_game_start,
  input  logic            i_cal_frame,
  input  logic [PX_W-1:0] i_platX,
  input  logic [PY_W-1:0] i_platY,
  ball_step_ctrl_if.master ball,
  output logic            o_frame_done,
  output logic            o_life_lost,
  output logic            o_err,
  output logic [2:0]      o_state
);
  // One extra bit so sums like X+S never wrap.
  localparam int AW = PX_W + 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0]    PLAT_W    = AW'(2 ** PLAT_W_LOG2);
  localparam logic [DIR_W-1:0] DIR_RESET = DIR_W'(9);
  localparam logic [DIR_W-1:0] DIR_FLIPX = DIR_W'(18);
  localparam logic [DIR_W-1:0] DIR_FLIPY = DIR_W'(19);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_CHECK = 3'd2,
    ST_HIT   = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5,
    ST_DEAD  = 3'd6
  } state_t;

  state_t state, state_n;

  // Step data captured on ack, evaluated one cycle later in CHECK.
  logic [PX_W-1:0]  lat_x;
  logic [PY_W-1:0]  lat_y;
  logic [BS_W-1:0]  lat_s;
  logic [1:0]       lat_spx, lat_spy;
  // Direction registers: 1 = positive (right / down).
  logic             dx_pos, dy_pos;
  logic [DIR_W-1:0] direc;
  logic             err, frame_done, life_lost;
  logic [CW-1:0]    wait_cnt;

  // FSM side outputs
  logic             req_c, coll_c, latch_en, dir_load, err_set, done_set, life_set;
  logic             dx_n, dy_n;
  logic [DIR_W-1:0] dir_n;

  // Collision datapath
  logic [AW-1:0]    x_e, y_e, s_e, px_e, py_e, xs, ys, center, offs;
  logic             dx_c, dy_c;
  logic             hit_floor, hit_plat, hit_left, hit_right, hit_top;
  logic [DIR_W-1:0] plat_dir;

  // Geometry of the latched step against the current platform position.
  always_comb begin
    x_e    = AW'(lat_x);
    y_e    = AW'(lat_y);
    s_e    = AW'(lat_s);
    px_e   = AW'(i_platX);
    py_e   = AW'(i_platY);
    xs     = x_e + s_e;
    ys     = y_e + s_e;
    center = x_e + (s_e >> 1);
    offs   = (center - px_e) >> (PLAT_W_LOG2 - 4);
    // A zero speed keeps the previous sign.
    dx_c   = (lat_spx == 2'b00) ? dx_pos : ~lat_spx[1];
    dy_c   = (lat_spy == 2'b00) ? dy_pos : ~lat_spy[1];

    hit_floor = (ys >= AW'(SCREEN_H - 1));
    hit_plat  = dy_c && ((ys + AW'(1)) >= py_e) && (ys <= (py_e + AW'(1))) &&
                (xs >= px_e) && (x_e <= (px_e + PLAT_W - AW'(1)));
    hit_left  = !dx_c && (x_e == '0);
    hit_right = dx_c && (xs >= AW'(SCREEN_W - 1));
    hit_top   = !dy_c && (y_e <= AW'(WALL_TOP));

    // Platform angle: 16 buckets across the platform, clamped to 1..16.
    if (center < px_e)           plat_dir = DIR_W'(1);
    else if (offs >= AW'(16))    plat_dir = DIR_W'(16);
    else                         plat_dir = DIR_W'(offs + AW'(1));
  end

  // Next-state and control decode.
  always_comb begin
    state_n  = state;
    req_c    = 1'b0;
    coll_c   = 1'b0;
    latch_en = 1'b0;
    dir_load = 1'b0;
    err_set  = 1'b0;
    done_set = 1'b0;
    life_set = 1'b0;
    dx_n     = dx_pos;
    dy_n     = dy_pos;
    dir_n    = direc;

    case (state)
      ST_IDLE: if (i_cal_frame) state_n = ST_REQ;
      ST_REQ: begin
        req_c = 1'b1;
        if (ball.i_ball_ack) begin
          latch_en = 1'b1;
          state_n  = ST_CHECK;
        end else if (ball.i_ball_frame_term) begin
          done_set = 1'b1;
          state_n  = ST_DONE;
        end else if (wait_cnt == CW'(TIMEOUT)) begin
          err_set  = 1'b1;
          done_set = 1'b1;
          state_n  = ST_DONE;
        end
      end
      ST_CHECK: begin
        dx_n    = dx_c;
        dy_n    = dy_c;
        state_n = ST_GAP;
        if (hit_floor) begin
          life_set = 1'b1;
          state_n  = ST_DEAD;
        end else if (hit_plat) begin
          dir_load = 1'b1;
          dir_n    = plat_dir;
          dy_n     = 1'b0;
          dx_n     = (plat_dir > DIR_W'(8));
          state_n  = ST_HIT;
        end else if (hit_left || hit_right) begin
          dir_load = 1'b1;
          dir_n    = DIR_FLIPX;
          dx_n     = ~dx_c;
          state_n  = ST_HIT;
        end else if (hit_top) begin
          dir_load = 1'b1;
          dir_n    = DIR_FLIPY;
          dy_n     = 1'b1;
          state_n  = ST_HIT;
        end
      end
      ST_HIT: begin
        coll_c  = 1'b1;
        state_n = ST_GAP;
      end
      ST_GAP:  state_n = ST_REQ;
      ST_DONE: if (i_cal_frame) state_n = ST_REQ;
      ST_DEAD: state_n = ST_DEAD;
      default: state_n = ST_IDLE;
    endcase

    if (i_game_start) state_n = ST_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Step latch, direction, wait counter and registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_x      <= '0;
      lat_y      <= '0;
      lat_s      <= '0;
      lat_spx    <= '0;
      lat_spy    <= '0;
      dx_pos     <= 1'b1;
      dy_pos     <= 1'b0;
      direc      <= DIR_RESET;
      err        <= 1'b0;
      frame_done <= 1'b0;
      life_lost  <= 1'b0;
      wait_cnt   <= '0;
    end else if (i_game_start) begin
      lat_x      <= '0;
      lat_y      <= '0;
      lat_s      <= '0;
      lat_spx    <= '0;
      lat_spy    <= '0;
      dx_pos     <= 1'b1;
      dy_pos     <= 1'b0;
      direc      <= DIR_RESET;
      err        <= 1'b0;
      frame_done <= 1'b0;
      life_lost  <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      if (latch_en) begin
        lat_x   <= ball.i_ballX;
        lat_y   <= ball.i_ballY;
        lat_s   <= ball.i_ball_size;
        lat_spx <= ball.i_ball_speedX;
        lat_spy <= ball.i_ball_speedY;
      end
      dx_pos     <= dx_n;
      dy_pos     <= dy_n;
      if (dir_load) direc <= dir_n;
      err        <= err | err_set;
      frame_done <= done_set;
      life_lost  <= life_set;
      // Counts cycles spent waiting in one request; restarts per request.
      wait_cnt   <= (state == ST_REQ && state_n == ST_REQ) ? wait_cnt + CW'(1) : '0;
    end
  end

  assign ball.o_ball_req       = req_c;
  assign ball.o_ball_collision = coll_c;
  assign ball.o_direc_var      = direc;
  assign o_frame_done          = frame_done;
  assign o_life_lost           = life_lost;
  assign o_err                 = err;
  assign o_state               = state;
endmodule
